rv32i_prog_loader: RTL and testbench

Instruction-memory program loader: the writer side of the instruction fetch path. It accepts a framed byte stream (header, payload, checksum), assembles the payload into little-endian 32-bit words and writes them through the instruction RAM write port. The fetched core is held in reset for the whole load. It sits beside rv32i_syncDualPortRam at the top level, driving the write port that the instruction fetch stage never uses.

---
 rtl/rv32i_loader_pkg.sv | 22 ++
 rtl/rv32i_byte_assembler.sv | 49 ++++
 rtl/rv32i_prog_loader.sv | 166 ++++++++++++++++
 tb/tb_rv32i_prog_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_loader_pkg.sv
`default_nettype none
// ============================================================================
// rv32i_loader_pkg : shared types and constants for the instruction loader
// Revision: 1.0
// ============================================================================
package rv32i_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } loader_state_t;

    localparam int         HDR_BYTES  = 4;
    localparam int         CSUM_BYTES = 4;
    localparam logic [3:0] WR_BE_ALL  = 4'hF;

endpackage
`default_nettype wire

// File: rtl/rv32i_byte_assembler.sv
`default_nettype none
// ============================================================================
// rv32i_byte_assembler : packs a byte stream into little-endian 32-bit words
// Revision: 1.0
// ============================================================================
module rv32i_byte_assembler
    import rv32i_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_LANE = 2'(HDR_BYTES - 1);

    logic [1:0]  lane_q, lane_d;
    // The fourth byte goes straight to the output, so only three are held.
    logic [23:0] shreg_q, shreg_d;

    always_comb begin
        lane_d  = lane_q;
        shreg_d = shreg_q;
        if (clear) begin
            lane_d = 2'd0;
        end else if (in_valid) begin
            lane_d  = lane_q + 2'd1;
            shreg_d = {in_data, shreg_q[23:8]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q  <= 2'd0;
            shreg_q <= 24'd0;
        end else begin
            lane_q  <= lane_d;
            shreg_q <= shreg_d;
        end
    end

    assign word_valid = in_valid && !clear && (lane_q == LAST_LANE);
    assign word       = {in_data, shreg_q};

endmodule
`default_nettype wire

// File: rtl/rv32i_prog_loader.sv
`default_nettype none
// ============================================================================
// rv32i_prog_loader : framed byte-stream loader driving the instruction RAM
// write port while holding the core in reset. Revision: 1.0
// ============================================================================
module rv32i_prog_loader
    import rv32i_loader_pkg::*;
#(
    parameter int          WORDS      = 1024,
    parameter logic [29:0] BASE_WADDR = 30'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        wr_en,
    output logic [31:2] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_be,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] MAX_WORDS = 32'(WORDS);

    loader_state_t state_q, state_d;
    logic [31:0]   n_q, n_d;
    logic [31:0]   wcnt_q, wcnt_d;
    logic [31:0]   acc_q, acc_d;
    logic          wr_en_q, wr_en_d;
    logic [29:0]   wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [3:0]    wr_be_q, wr_be_d;
    logic          core_reset_q, core_reset_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          start_accept;
    logic          byte_fire;
    logic          word_valid;
    logic [31:0]   word;

    assign busy      = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign s_ready   = busy;
    assign byte_fire = s_valid && busy;

    rv32i_byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_accept),
        .in_valid   (byte_fire),
        .in_data    (s_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        wcnt_d       = wcnt_q;
        acc_d        = acc_q;
        wr_en_d      = 1'b0;
        wr_be_d      = 4'h0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        error_d      = error_q;
        start_accept = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_d      = ST_HDR;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    acc_d        = 32'd0;
                    wcnt_d       = 32'd0;
                    core_reset_d = 1'b1;
                end
            end
            ST_HDR: begin
                if (word_valid) begin
                    n_d = word;
                    if (word > MAX_WORDS) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else if (word == 32'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    wr_en_d   = 1'b1;
                    wr_be_d   = WR_BE_ALL;
                    wr_addr_d = BASE_WADDR + wcnt_q[29:0];
                    wr_data_d = word;
                    acc_d     = acc_q + word;
                    wcnt_d    = wcnt_q + 32'd1;
                    if (wcnt_q + 32'd1 == n_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                // A start arriving with the last checksum byte is dropped here.
                if (word_valid) begin
                    if (word == acc_q) begin
                        state_d      = ST_DONE;
                        done_d       = 1'b1;
                        core_reset_d = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            n_q          <= 32'd0;
            wcnt_q       <= 32'd0;
            acc_q        <= 32'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 30'd0;
            wr_data_q    <= 32'd0;
            wr_be_q      <= 4'h0;
            core_reset_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            wcnt_q       <= wcnt_d;
            acc_q        <= acc_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_be_q      <= wr_be_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_be      = wr_be_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_rv32i_prog_loader : directed frames with hand-computed expected results
// Revision: 1.0
// ============================================================================
module tb_rv32i_prog_loader;

    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        wr_en;
    logic [31:2] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        error;

    int          errors = 0;
    int          checks = 0;
    logic [29:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          be_bad = 0;
    int          rdy_low = 0;
    bit          in_session = 1'b0;

    rv32i_prog_loader #(.WORDS(WORDS), .BASE_WADDR(30'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            if (wr_be !== 4'hF) be_bad++;
        end else if (wr_be !== 4'h0) begin
            be_bad++;
        end
        if (in_session && s_ready !== 1'b1) rdy_low++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (s_ready !== 1'b1) check("ready_timeout", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    // Two-word program; status bits are {done, error, core_reset, busy, s_ready}.
    task automatic run_frame2(input int gap, input logic [31:0] csum, input logic good);
        logic [31:0] c;
        c = csum;
        clear_log();
        pulse_start();
        check("start_status", {59'd0, done, error, core_reset, busy, s_ready}, 64'b00111);
        in_session = 1'b1;
        send_word(32'd2, gap);
        send_word(32'h00500093, gap);
        if (gap == 0) check("wr0_pulse", {31'd0, wr_en, wr_data}, {31'd0, 1'b1, 32'h00500093});
        pulse_start();
        if (gap == 0) check("wr0_one_cycle", 64'(wr_en), 64'd0);
        send_word(32'h00A00113, gap);
        for (int k = 0; k < 3; k++) send_byte(c[8*k +: 8], gap == 0 ? 0 : 1);
        check("pre_last_csum", {62'd0, done, core_reset}, 64'b01);
        send_byte(c[31:24], 0);
        in_session = 1'b0;
        if (good)
            check("csum_good_status", {59'd0, done, error, core_reset, busy, s_ready}, 64'b10000);
        else
            check("csum_bad_status", {59'd0, done, error, core_reset, busy, s_ready}, 64'b01100);
        check("frame2_writes", 64'(wa_q.size()), 64'd2);
        if (wa_q.size() == 2) begin
            check("frame2_w0", {wa_q[0], wd_q[0]}, {30'd0, 32'h00500093});
            check("frame2_w1", {wa_q[1], wd_q[1]}, {30'd1, 32'h00A00113});
        end
    endtask

    initial begin
        repeat (2) tick();
        check("reset_ctl", {54'd0, s_ready, wr_en, wr_be, core_reset, busy, done, error}, 64'd0);
        check("reset_data", {2'd0, wr_addr, wr_data}, 64'd0);
        reset = 1'b0;
        tick();

        // Checksum is the sum of the two payload words: 0x00F001A6.
        run_frame2(0, 32'h00F001A6, 1'b1);
        run_frame2(1, 32'h00F001A6, 1'b1);
        run_frame2(0, 32'h00F001A5, 1'b0);

        // Empty program, start coinciding with the final checksum byte.
        clear_log();
        pulse_start();
        send_word(32'd0, 0);
        for (int k = 0; k < 3; k++) send_byte(8'h00, 0);
        start = 1'b1;
        send_byte(8'h00, 0);
        start = 1'b0;
        check("n0_done", {59'd0, done, error, core_reset, busy, s_ready}, 64'b10000);
        tick();
        check("n0_start_dropped", 64'(busy), 64'd0);
        check("n0_writes", 64'(wa_q.size()), 64'd0);

        pulse_start();
        send_word(32'd0, 0);
        send_word(32'd1, 0);
        check("n0_bad_csum", {59'd0, done, error, core_reset, busy, s_ready}, 64'b01100);

        // Oversize header.
        clear_log();
        pulse_start();
        send_word(32'd1025, 0);
        check("hdr_too_big", {59'd0, done, error, core_reset, busy, s_ready}, 64'b01100);
        s_valid = 1'b1;
        s_data  = 8'h5A;
        tick();
        check("err_not_ready", 64'(s_ready), 64'd0);
        s_valid = 1'b0;
        check("hdr_err_writes", 64'(wa_q.size()), 64'd0);

        // Maximum legal header is accepted, then aborted by reset.
        pulse_start();
        send_word(32'd1024, 0);
        check("hdr_max_ok", {59'd0, done, error, core_reset, busy, s_ready}, 64'b00111);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Reset after the sixth payload byte of an N=4 load.
        clear_log();
        pulse_start();
        send_word(32'd4, 0);
        send_word(32'hA1A2A3A4, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        reset = 1'b1;
        #2;
        check("abort_ctl", {54'd0, s_ready, wr_en, wr_be, core_reset, busy, done, error}, 64'd0);
        check("abort_data", {2'd0, wr_addr, wr_data}, 64'd0);
        tick();
        reset = 1'b0;
        tick();
        check("abort_writes", 64'(wa_q.size()), 64'd1);
        if (wa_q.size() == 1) check("abort_w0", {wa_q[0], wd_q[0]}, {30'd0, 32'hA1A2A3A4});

        // Fresh N=3 load; 0x13 + 0x12345678 + 0xFFFFFFF0 wraps to 0x1234567B.
        clear_log();
        pulse_start();
        send_word(32'd3, 0);
        send_word(32'h00000013, 0);
        send_word(32'h12345678, 0);
        send_word(32'hFFFFFFF0, 0);
        send_word(32'h1234567B, 0);
        check("reload_status", {59'd0, done, error, core_reset, busy, s_ready}, 64'b10000);
        check("reload_writes", 64'(wa_q.size()), 64'd3);
        if (wa_q.size() == 3) begin
            check("reload_w0", {wa_q[0], wd_q[0]}, {30'd0, 32'h00000013});
            check("reload_w1", {wa_q[1], wd_q[1]}, {30'd1, 32'h12345678});
            check("reload_w2", {wa_q[2], wd_q[2]}, {30'd2, 32'hFFFFFFF0});
        end

        check("wr_be_rule", 64'(be_bad), 64'd0);
        check("ready_held", 64'(rdy_low), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
